// File: rtl/fbcpu_memory.sv
// Program memory and boot controller for the FBCPU core: 64x10 read-first RAM,
// streaming loader that holds the core in reset, and a memory-mapped output register.
module fbcpu_memory #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int OUT_ADDR      = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_WIDTH-1:0]    load_data,
  input  logic                     load_last,
  output logic                     load_ready,
  input  logic                     run_start,
  output logic                     cpu_rst,
  output logic [1:0]               mem_state,
  input  logic [ADDRESS_WIDTH-1:0] MAR,
  input  logic                     RAMWr,
  input  logic [DATA_WIDTH-1:0]    MDRIn,
  output logic [DATA_WIDTH-1:0]    MDROut,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] OUT_A   = ADDRESS_WIDTH'(OUT_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic                     load_wr, core_wr;

  // A restart pulse in LOAD drops the coincident word.
  assign load_wr = !rst && state == LOAD && load_valid && !load_start;
  assign core_wr = !rst && state == RUN && RAMWr;

  assign cpu_rst    = state != RUN;
  assign load_ready = state == LOAD;
  assign mem_state  = state;

  // RAM is deliberately not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (load_wr)      mem[cnt] <= load_data;
    else if (core_wr) mem[MAR] <= MDRIn;
  end

  // Read-first: the read samples the array before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (rst) MDROut <= '0;
    else     MDROut <= mem[MAR];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end else if (run_start) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (load_start) begin
            cnt <= '0;
          end else if (load_valid) begin
            cnt <= cnt + 1'b1;
            if (load_last || cnt == CNT_MAX) state <= RUN;
          end
        end
        RUN: begin
          if (RAMWr && MAR == OUT_A) begin
            out_data  <= MDRIn;
            out_valid <= 1'b1;
          end
          if (load_start) begin
            state <= LOAD;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fbcpu_memory.sv
// Directed bench for fbcpu_memory: a transaction-level model checked every cycle,
// plus literal expectations for the loaded program, output port and reset behaviour.
module tb_fbcpu_memory;
  logic       clk = 0;
  logic       rst, load_start, load_valid, load_last, run_start, RAMWr;
  logic [9:0] load_data, MDRIn;
  logic [5:0] MAR;
  logic       load_ready, cpu_rst, out_valid;
  logic [1:0] mem_state;
  logic [9:0] MDROut, out_data;

  int vectors = 0, miscompares = 0;

  fbcpu_memory dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .run_start(run_start), .cpu_rst(cpu_rst), .mem_state(mem_state),
    .MAR(MAR), .RAMWr(RAMWr), .MDRIn(MDRIn), .MDROut(MDROut),
    .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: which mode we are in, where the next load word goes, and the array itself.
  int         m_mode;   // 0 idle, 1 loading, 2 running
  int         m_next;
  logic [9:0] m_mem [64];
  bit         m_known [64];
  logic [9:0] m_rd, m_out;
  bit         m_rd_known, m_pulse, m_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_next = 0; m_rd = 0; m_rd_known = 1; m_out = 0; m_pulse = 0; m_en = 1;
    end else begin
      m_rd = m_mem[MAR];
      m_rd_known = m_known[MAR];
      m_pulse = 0;
      if (m_mode == 0) begin
        if (load_start) begin m_mode = 1; m_next = 0; end
        else if (run_start) m_mode = 2;
      end else if (m_mode == 1) begin
        if (load_start) m_next = 0;
        else if (load_valid) begin
          m_mem[m_next] = load_data;
          m_known[m_next] = 1;
          if (load_last || m_next == 63) m_mode = 2;
          m_next = (m_next + 1) % 64;
        end
      end else begin
        if (RAMWr) begin
          m_mem[MAR] = MDRIn;
          m_known[MAR] = 1;
          if (MAR == 63) begin m_out = MDRIn; m_pulse = 1; end
        end
        if (load_start) begin m_mode = 1; m_next = 0; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("mem_state", mem_state, m_mode);
      chk("cpu_rst", cpu_rst, m_mode != 2);
      chk("load_ready", load_ready, m_mode == 1);
      chk("out_data", out_data, m_out);
      chk("out_valid", out_valid, m_pulse);
      if (m_rd_known) chk("MDROut", MDROut, m_rd);
    end
  end

  // Drive inputs shortly after the edge, then let the next edge sample them.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_start = 0; load_valid = 0; load_last = 0; load_data = 0;
    run_start = 0; RAMWr = 0; MDRIn = 0;
  endtask

  task automatic read_expect(input string name, input int addr, input int exp);
    MAR = 6'(addr);
    step();
    chk(name, MDROut, exp);
  endtask

  logic [9:0] words [4] = '{10'h005, 10'h083, 10'h0BF, 10'h200};

  initial begin
    idle_inputs();
    MAR = 0; rst = 1;
    step(); step();
    rst = 0;
    chk("reset_state", mem_state, 0);
    chk("reset_cpu_rst", cpu_rst, 1);
    chk("reset_load_ready", load_ready, 0);
    chk("reset_mdrout", MDROut, 0);
    chk("reset_out_valid", out_valid, 0);

    // Short load terminated by load_last.
    load_start = 1; step(); load_start = 0;
    chk("load_ready_in_load", load_ready, 1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1; load_data = words[i]; load_last = (i == 3);
      step();
    end
    idle_inputs();
    chk("run_after_last", mem_state, 2);
    chk("cpu_rst_fell", cpu_rst, 0);
    for (int i = 0; i < 4; i++) read_expect("read_loaded", i, words[i]);
    chk("model_word2", m_mem[2], 10'h0BF);

    // Output register.
    RAMWr = 1; MAR = 63; MDRIn = 10'h155; step();
    RAMWr = 0;
    chk("out_data_155", out_data, 10'h155);
    chk("out_valid_pulse", out_valid, 1);
    step();
    chk("out_valid_single", out_valid, 0);
    chk("read_63_new", MDROut, 10'h155);
    RAMWr = 1; MAR = 62; MDRIn = 10'h2AA; step();
    RAMWr = 0;
    chk("no_pulse_62", out_valid, 0);

    // Read-first on a same-address read/write.
    RAMWr = 1; MAR = 62; MDRIn = 10'h111; step();
    RAMWr = 0;
    chk("read_first_old", MDROut, 10'h2AA);
    step();
    chk("read_after_write", MDROut, 10'h111);

    // Full-depth load, gapped valid, no load_last.
    load_start = 1; step(); load_start = 0;
    chk("reload_from_run", mem_state, 1);
    for (int i = 0; i < 64; i++) begin
      load_valid = 1; load_data = 10'(i); step();
      load_valid = 0;
      if (i < 63) begin
        chk("still_loading", mem_state, 1);
        step();
      end
    end
    chk("run_after_63", mem_state, 2);
    for (int i = 0; i < 64; i++) read_expect("full_load_word", i, i);

    // Restart mid-load drops the coincident word.
    load_start = 1; step(); load_start = 0;
    load_valid = 1; load_data = 10'h3AB; step();
    load_start = 1; load_data = 10'h0EE; step();
    load_start = 0; load_data = 10'h077; load_last = 1; step();
    idle_inputs();
    chk("restart_run", mem_state, 2);
    read_expect("restart_addr0", 0, 10'h077);
    read_expect("dropped_word", 1, 10'h001);

    // Reset mid-run keeps RAM; both pulses in IDLE favour load.
    rst = 1; step(); rst = 0;
    chk("rst_idle", mem_state, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    read_expect("retained_idle", 0, 10'h077);
    load_start = 1; run_start = 1; step(); idle_inputs();
    chk("load_wins", mem_state, 1);
    rst = 1; step(); rst = 0;
    run_start = 1; MAR = 0; step(); run_start = 0;
    chk("direct_run", mem_state, 2);
    chk("direct_cpu_rst", cpu_rst, 0);
    step();
    chk("pc0_fetch", MDROut, 10'h077);
    run_start = 1; step(); run_start = 0;
    chk("run_start_ignored", mem_state, 2);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fbcpu_memory.md
# fbcpu_memory

Program memory and boot controller sitting directly below the FBCPU core. It holds the 64×10 unified instruction/data RAM and serves the core's MAR/RAMWr/MDRIn/MDROut port. A streaming loader fills the RAM before execution and holds the core in reset until the program is loaded. A memory-mapped output register at `OUT_ADDR` captures core stores so results are observable.

## Interface
- `ADDRESS_WIDTH`, 6, RAM address width; depth = 2^ADDRESS_WIDTH (64).
- `DATA_WIDTH`, 10, word width.
- `OUT_ADDR`, 63, address whose core writes also update `out_data`.

- `clk` input 1: clock; all state changes on posedge.
- `rst` input 1: reset, synchronous, active-high.
- `load_start` input 1: one-cycle pulse; (re)starts a load at address 0.
- `load_valid` input 1: `load_data` is valid.
- `load_data` input DATA_WIDTH: program word.
- `load_last` input 1: qualifies the final word of the load.
- `load_ready` output 1: high only in LOAD.
- `run_start` input 1: pulse; enters RUN from IDLE without loading.
- `cpu_rst` output 1: reset to the core; high whenever the state is not RUN.
- `mem_state` output 2: 0 = IDLE, 1 = LOAD, 2 = RUN.
- `MAR` input ADDRESS_WIDTH: core address.
- `RAMWr` input 1: core write enable.
- `MDRIn` input DATA_WIDTH: core write data.
- `MDROut` output DATA_WIDTH: registered read data.
- `out_data` output DATA_WIDTH: last value the core stored to `OUT_ADDR`.
- `out_valid` output 1: one-cycle pulse when `out_data` updates.

## Operation
- **Reset values**
  - State: IDLE.
  - Load counter: 0.
  - `MDROut`, `out_data`, `out_valid`: 0.
  - RAM contents are not cleared and survive `rst`.
- **IDLE**
  - `cpu_rst` = 1, `load_ready` = 0.
  - `load_start` → LOAD.
  - `run_start` → RUN.
  - If both pulse in the same cycle, `load_start` wins.
- **LOAD**
  - `cpu_rst` = 1, `load_ready` = 1.
  - Each cycle with `load_valid` high: write `mem[cnt] <= load_data`, then `cnt <= cnt + 1`.
  - The transfer with `load_last` high, or the transfer at `cnt` = 63, moves the FSM to RUN on the next edge.
  - At `cnt` = 63 the counter wraps to 0; no further words are accepted.
  - `load_start` in LOAD resets `cnt` to 0 and stays in LOAD. Any `load_valid` in that same cycle is dropped (not written).
  - Core port writes are ignored in LOAD.
- **RUN**
  - `cpu_rst` = 0.
  - `RAMWr` high: `mem[MAR] <= MDRIn`.
  - If additionally `MAR == OUT_ADDR`: `out_data <= MDRIn` and `out_valid` = 1 for the following cycle.
  - `load_start` → LOAD (core re-held in reset, `cnt` = 0).
  - `run_start` is ignored.
- **Read path**
  - Every cycle, in all states: `MDROut <= mem[MAR]`.
  - Read-during-write to the same address returns the old word (read-first).
- `out_valid` is a registered pulse: never high for 2 consecutive cycles unless the core writes `OUT_ADDR` on consecutive cycles.

## Timing
- Read latency is 1 cycle: address on `MAR` at edge N gives data on `MDROut` after edge N.
  - This matches the core's fetch: address set in core state 0, word consumed in core state 1.
- Write latency: the RAM updates on the edge where `RAMWr` is sampled high.
  - A read of the same address on the next cycle returns the new word.
- `cpu_rst` is decoded from the state register.
  - It falls on the edge entering RUN and rises on the edge entering LOAD or IDLE.
  - Because the core's reset is synchronous, the core starts fetching at PC = 0 on the first RUN cycle.
- Load throughput: 1 word per cycle while `load_valid` is held high.
- `rst` asserted mid-LOAD or mid-RUN:
  - Next edge returns to IDLE with counter 0.
  - Partially loaded RAM contents are kept.

## Test plan
- **Reset:** assert `rst` 2 cycles → `mem_state` = 0, `cpu_rst` = 1, `load_ready` = 0, `MDROut` = 0, `out_valid` = 0.
- **Load with `load_last`:** `load_start`, then 4 back-to-back words 0x005, 0x083, 0x0BF, 0x200 with `load_last` on the 4th.
  - Expect the FSM in RUN 1 cycle after the 4th transfer and `cpu_rst` falling.
  - Reading `MAR` = 0..3 returns those words 1 cycle later.
- **Full-depth load:** 64 words with no `load_last`, `load_valid` gapped every other cycle.
  - Expect `mem[i]` = i for all i, RUN entered after word 63, and the counter back at 0.
- **Output port:** in RUN, `RAMWr` = 1, `MAR` = 63, `MDRIn` = 0x155.
  - Expect `out_data` = 0x155 and a single-cycle `out_valid` pulse.
  - A subsequent read of 63 returns 0x155.
  - A write to `MAR` = 62 does not pulse `out_valid`.
- **Restart and read-first:**
  - `load_start` coincident with `load_valid` in LOAD → that word is not written; the next word lands at address 0.
  - Same-address read and write in one cycle → `MDROut` shows the old value.
- **Reset mid-run and direct start:** `rst` during RUN → IDLE with `cpu_rst` = 1 and RAM retained; `run_start` → RUN, and the core re-executes the retained program from PC = 0.
